// File: rtl/counter_pkg.sv
// Shared constants for the counter controller: direction encoding, default
// timing parameters and a counter-width helper.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int TICK_DIV_DEF        = 32'd50000000;
   localparam int DEBOUNCE_CYCLES_DEF = 32'd500000;

   // Width of a counter covering 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n > 32'sd1) begin
         return $clog2(n);
      end else begin
         return 32'sd1;
      end
   endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Button inputs and counter-control outputs of counter_ctrl, bundled for
// connection between the controller and its driver/consumer.
interface counter_ctrl_if;

   logic btn_dir;
   logic btn_pause;
   logic clk_en;
   logic up;
   logic paused;

   modport master (output btn_dir, output btn_pause,
                   input  clk_en,  input  up, input paused);

   modport slave  (input  btn_dir, input  btn_pause,
                   output clk_en,  output up, output paused);

endinterface

// File: rtl/counter_ctrl_debounce.sv
// Button conditioner: two-flop synchronizer, debounce counter, and a one-cycle
// press pulse on each accepted 0->1 level change.
module debounce
   import counter_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic press
);

   localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          press_r;
   logic [CW-1:0] cnt_r;

   // Synchronize, then accept a new level only after it held for the full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         press_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
               level_r <= sync2_r;
               press_r <= sync2_r;
               cnt_r   <= '0;
            end else begin
               press_r <= 1'b0;
               cnt_r   <= cnt_r + CNT_ONE;
            end
         end else begin
            press_r <= 1'b0;
            cnt_r   <= '0;
         end
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/counter_ctrl.sv
// Tick prescaler plus debounced direction/pause toggles driving a downstream
// 4-bit up/down counter.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int TICK_DIV        = TICK_DIV_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          rst,
   counter_ctrl_if.slave bus
);

   localparam int            DW       = cnt_width(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   logic          dir_level_s;
   logic          dir_press_s;
   logic          pause_level_s;
   logic          pause_press_s;
   logic          dir_tgl_s;
   logic          pause_tgl_s;
   logic          run_s;
   logic [DW-1:0] div_cnt_r;
   logic          clk_en_r;
   logic          up_r;
   logic          paused_r;

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_db (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.btn_dir),
      .level (dir_level_s),
      .press (dir_press_s)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
      .clk   (clk),
      .rst   (rst),
      .din   (bus.btn_pause),
      .level (pause_level_s),
      .press (pause_press_s)
   );

   // Toggle requests; a pause toggle blocks counting on its own edge so a
   // pause that lands on terminal count suppresses the tick.
   always_comb begin
      dir_tgl_s   = dir_press_s & dir_level_s;
      pause_tgl_s = pause_press_s & pause_level_s;
      run_s       = 1'b0;
      if (!paused_r && !pause_tgl_s) begin
         run_s = 1'b1;
      end else begin
         run_s = 1'b0;
      end
   end

   // Prescaler, tick pulse and toggle registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_r <= '0;
         clk_en_r  <= 1'b0;
         up_r      <= DIR_UP;
         paused_r  <= 1'b0;
      end else begin
         up_r     <= up_r ^ dir_tgl_s;
         paused_r <= paused_r ^ pause_tgl_s;
         if (run_s) begin
            if (div_cnt_r == DIV_LAST) begin
               div_cnt_r <= '0;
               clk_en_r  <= 1'b1;
            end else begin
               div_cnt_r <= div_cnt_r + DIV_ONE;
               clk_en_r  <= 1'b0;
            end
         end else begin
            clk_en_r <= 1'b0;
         end
      end
   end

   assign bus.clk_en = clk_en_r;
   assign bus.up     = up_r;
   assign bus.paused = paused_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_counter_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   counter_ctrl_if bus();

   counter_ctrl #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until a tick pulse is seen, leaving the prescaler at count 0.
   task automatic wait_en();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.clk_en === 1'b1) break;
      end
      check_val("wait_en", bus.clk_en, 1'b1);
   endtask

   // Hold the chosen buttons 10 cycles, observe 18 cycles; toggle lands on cycle 6.
   task automatic press_and_check(input string tag, input logic bd, input logic bp,
                                  input logic up0, input logic up1,
                                  input logic p0, input logic p1,
                                  input logic chk_en, input logic [17:0] en_mask);
      bus.btn_dir   = bd;
      bus.btn_pause = bp;
      for (int n = 1; n <= 18; n++) begin
         tick();
         if (n == 10) begin
            bus.btn_dir   = 1'b0;
            bus.btn_pause = 1'b0;
         end
         check_val({tag, "_up"}, bus.up, (n >= 6) ? up1 : up0);
         check_val({tag, "_paused"}, bus.paused, (n >= 6) ? p1 : p0);
         if (chk_en) check_val({tag, "_clk_en"}, bus.clk_en, en_mask[n-1]);
      end
   endtask

   initial begin
      logic [11:0] gpat;
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.btn_dir   = 1'b0;
      bus.btn_pause = 1'b0;
      tick();
      tick();
      check_val("rst_clk_en", bus.clk_en, 1'b0);
      check_val("rst_up", bus.up, 1'b1);
      check_val("rst_paused", bus.paused, 1'b0);

      rst = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         tick();
         check_val("run_clk_en", bus.clk_en, (n % 4) == 0);
         check_val("run_up", bus.up, 1'b1);
         check_val("run_paused", bus.paused, 1'b0);
      end

      press_and_check("dir1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h08888);
      wait_en();
      tick();
      tick();
      press_and_check("dir2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 18'h22222);

      gpat = 12'b000101101011;
      for (int i = 0; i < 18; i++) begin
         bus.btn_dir = (i < 12) ? gpat[i] : 1'b0;
         tick();
         check_val("glitch_up", bus.up, 1'b1);
      end

      wait_en();
      press_and_check("pause_on", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 18'h00008);
      press_and_check("resume", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h11100);

      wait_en();
      tick();
      tick();
      press_and_check("pause_tc", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 18'h00002);
      press_and_check("resume_tc", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 18'h04440);

      press_and_check("both", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'h00000);

      bus.btn_dir = 1'b1;
      tick();
      tick();
      tick();
      #1;
      rst = 1'b1;
      #1;
      check_val("async_clk_en", bus.clk_en, 1'b0);
      check_val("async_up", bus.up, 1'b1);
      check_val("async_paused", bus.paused, 1'b0);
      bus.btn_dir = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         check_val("post_rst_clk_en", bus.clk_en, (n % 4) == 0);
         check_val("post_rst_up", bus.up, 1'b1);
         check_val("post_rst_paused", bus.paused, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per clk_en pulse; SHALL be at least 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, cycles a synchronized button level must hold before acceptance; SHALL be at least 1.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 btn_dir  input  1  raw, asynchronous, bouncing direction button; active-high.
REQ-006 btn_pause  input  1  raw, asynchronous, bouncing pause button; active-high.
REQ-007 clk_en  output  1  registered one-cycle enable pulse for the downstream 4-bit up/down counter.
REQ-008 up  output  1  registered count direction for the downstream counter: 1 = up, 0 = down.
REQ-009 paused  output  1  registered pause status: 1 = tick generation halted.

Function
REQ-010 The prescaler counter div_cnt SHALL have width clog2(TICK_DIV) and count 0..TICK_DIV-1, incrementing once per cycle while paused=0.
REQ-011 On the edge where div_cnt=TICK_DIV-1 and paused=0: div_cnt wraps to 0 and clk_en is 1 for exactly the following cycle; at all other times clk_en is 0.
REQ-012 While paused=1: div_cnt holds its value and clk_en stays 0; on resume, counting continues from the held value (no restart).
REQ-013 Each button path: 2-flop synchronizer, then debounce counter; the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality clears the debounce counter.
REQ-014 A press pulse SHALL be generated on each 0->1 transition of a debounced level; a 1->0 transition generates nothing.
REQ-015 Total latency from a clean raw 0->1 edge to the up or paused change SHALL be DEBOUNCE_CYCLES+3 rising edges.
REQ-016 Each btn_dir press pulse toggles up; each btn_pause press pulse toggles paused.
REQ-017 A button held high toggles its output once only; a new toggle requires release (debounced 0) and then a new press.
REQ-018 Simultaneous dir and pause press pulses SHALL both take effect on the same edge.
REQ-019 If an up toggle and a clk_en assertion occur on the same edge, both outputs update together, so the downstream counter samples the new direction.
REQ-020 If a pause toggle to 1 and a terminal count occur on the same edge, the pause wins: no clk_en pulse, and div_cnt holds at TICK_DIV-1.
REQ-021 A resume toggle at terminal count SHALL produce the clk_en pulse one cycle later.

Reset
REQ-022 While rst=1, the block SHALL immediately, without a clock edge, force clk_en=0, up=1, paused=0, div_cnt=0, all synchronizer flops and debounced levels to 0, and debounce counters to 0.
REQ-023 Reset asserted mid-operation SHALL discard any in-progress debounce and any pending toggle.
REQ-024 After rst deasserts, the first clk_en pulse SHALL follow TICK_DIV rising edges later.

Structure
REQ-025 Shared package/header counter_pkg holds DIR_UP=1 and DIR_DOWN=0, plus the default TICK_DIV and DEBOUNCE_CYCLES values.
REQ-026 Sub-module debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, din, level, press) SHALL be instantiated twice.
REQ-027 Prescaler and toggle registers SHALL reside in counter_ctrl.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-028 Release reset, buttons low -> clk_en high for 1 cycle on edges 4, 8, 12 after release; up=1, paused=0 throughout.
REQ-029 Clean btn_dir pulse high for 10 cycles -> up falls exactly 6 edges after the raw rise; no second toggle while held; a second press restores up=1.
REQ-030 btn_dir glitches of 1-2 cycles, repeated with 1-cycle gaps -> up unchanged.
REQ-031 btn_pause press with div_cnt=1 -> clk_en stops and paused=1; press again -> paused=0, and the next clk_en follows after the remaining 2 counts plus the pause-toggle alignment.
REQ-032 Assert rst asynchronously mid-count with up=0 and paused=1 -> clk_en=0, up=1, paused=0 before the next clk edge.
REQ-033 Raise both buttons on the same cycle -> up and paused toggle on the same edge.
